// File: rtl/cpu_pkg.sv
// Shared definitions for the load/store unit: RV32I load/store size codes
// and the LSU control states.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality check for a load/store: the size code must be a known
// one and the byte address must be naturally aligned for that size.
module lsu_align_check
  import cpu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  output logic       legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: legal_o = 1'b1;
      F3_H, F3_HU: legal_o = (addr_lo_i[0] == 1'b0);
      F3_W:        legal_o = (addr_lo_i == 2'b00);
      default:     legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: captures one op, performs a one-cycle
// access to a combinational data memory, then holds the response until taken.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [2:0]               mem_funct3,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  lsu_state_t               state_q, state_d;
  logic                     we_q, we_d;
  logic [2:0]               f3_q, f3_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     req_legal;

  lsu_align_check u_align_check (
    .funct3_i  (req_funct3),
    .addr_lo_i (req_addr[1:0]),
    .legal_o   (req_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = F3_W;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = ~req_legal;
          state_d = req_legal ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_funct3 = f3_q;
        // Reset must be able to kill a store in the very cycle it would commit.
        mem_wr_en  = we_q & ~rst;
        rdata_d    = we_q ? '0 : mem_rdata;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed little-endian
// data memory model that performs the size/sign handling itself.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  int passed = 0;
  int total  = 0;
  int wr_count = 0;

  logic [7:0] mem [0:1023] = '{default: 8'h00};
  logic [9:0] idx;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  assign idx = mem_addr[9:0];

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_funct3)
      3'b000: mem_rdata = {{24{mem[idx][7]}}, mem[idx]};
      3'b001: mem_rdata = {{16{mem[idx+10'd1][7]}}, mem[idx+10'd1], mem[idx]};
      3'b010: mem_rdata = {mem[idx+10'd3], mem[idx+10'd2], mem[idx+10'd1], mem[idx]};
      3'b100: mem_rdata = {24'h0, mem[idx]};
      3'b101: mem_rdata = {16'h0, mem[idx+10'd1], mem[idx]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wr_count <= wr_count + 1;
      mem[idx] <= mem_wdata[7:0];
      if (mem_funct3 == 3'b001 || mem_funct3 == 3'b010)
        mem[idx+10'd1] <= mem_wdata[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[idx+10'd2] <= mem_wdata[23:16];
        mem[idx+10'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Cycles (in negedges after the accepting edge) until rsp_valid appears.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 10);
  endtask

  task automatic op(input string tag, input logic we, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rdata, input logic exp_err,
                    input int exp_lat, input int exp_wr);
    int lat;
    int wr0;
    wr0 = wr_count;
    issue(we, f3, a, wd);
    wait_rsp(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    @(posedge clk);
    #1 chk({tag, "_writes"}, wr_count - wr0, exp_wr);
  endtask

  initial begin
    int lat;
    int wr0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
    chk("rst_rsp_rdata", rsp_rdata,          32'h0);
    chk("rst_mem_wr_en", {31'h0, mem_wr_en}, 32'h0);
    rst = 1'b0;

    op("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    op("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

    op("sb_203",  1'b1, 3'b000, 32'h203, 32'h12345680, 32'h0, 1'b0, 2, 1);
    op("lb_203",  1'b0, 3'b000, 32'h203, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
    op("lbu_203", 1'b0, 3'b100, 32'h203, 32'h0, 32'h00000080, 1'b0, 2, 0);
    op("lw_200",  1'b0, 3'b010, 32'h200, 32'h0, 32'h80000000, 1'b0, 2, 0);
    op("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 2, 0);

    op("lh_101_mis", 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0);
    op("sw_102_mis", 1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0);
    op("f3_011",     1'b1, 3'b011, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);
    op("lw_100_again", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

    // Response backpressure: result must stay put until taken.
    rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    wait_rsp(lat);
    chk("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("bp_done_req_ready", {31'h0, req_ready}, 32'h1);

    // Reset during the access cycle of a store drops it entirely.
    wr0 = wr_count;
    issue(1'b1, 3'b010, 32'h300, 32'h55555555);
    rst = 1'b1;
    #1 chk("rstacc_mem_wr_en", {31'h0, mem_wr_en}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstacc_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rstacc_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    chk("rstacc_no_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("rstacc_writes", wr_count - wr0, 0);
    op("lw_300", 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1'b0, 2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
